// File: rtl/codma_xfer_ctrl.sv
// rtl/codma_xfer_ctrl.sv - CODMA transfer sequencer: splits a descriptor into 32/16/8 B read-then-write chunks.
// Optional per-phase watchdog and timeout_o port enabled by CODMA_XFER_TIMEOUT_EN.
module codma_xfer_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  output logic              need_read_o,
  output logic              need_write_o,
  input  logic              rd_busy_i,
  input  logic              wr_busy_i,
  input  logic              bus_error_i,
  output logic [ADDR_W-1:0] chunk_addr_o,
  output logic [7:0]        chunk_size_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
`ifdef CODMA_XFER_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic [LEN_W-1:0]  bytes_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_NEXT, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q, bytes_done_q;
  logic              seen_q, done_q, error_q;
  logic [7:0]        size_code;
  logic [5:0]        chunk_bytes;
  logic [LEN_W-1:0]  chunk_len;
  logic              in_rd_phase, in_wr_phase;
  logic              tmo_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef CODMA_XFER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  assign tmo_hit   = ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // remaining only changes in NEXT, so the size is stable across a whole chunk
  always_comb begin
    size_code   = 8'd3;
    chunk_bytes = 6'd8;
    if (rem_q >= LEN_W'(32)) begin
      size_code   = 8'd9;
      chunk_bytes = 6'd32;
    end else if (rem_q >= LEN_W'(16)) begin
      size_code   = 8'd8;
      chunk_bytes = 6'd16;
    end
  end

  assign chunk_len = LEN_W'(chunk_bytes);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i == '0)             state_d = S_IDLE;
          else if (length_i[2:0] != 3'd0) state_d = S_ERR;
          else                            state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus_error_i || tmo_hit)    state_d = S_ERR;
        else if (seen_q && !rd_busy_i) state_d = S_WR_REQ;
      end
      S_WR_REQ:  state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus_error_i || tmo_hit)    state_d = S_ERR;
        else if (seen_q && !wr_busy_i) state_d = S_NEXT;
      end
      S_NEXT:    state_d = (rem_q == chunk_len) ? S_IDLE : S_RD_REQ;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      bytes_done_q <= '0;
      seen_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef CODMA_XFER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            rem_q        <= length_i;
            error_q      <= 1'b0;
            bytes_done_q <= '0;
            done_q       <= (length_i == '0);
`ifdef CODMA_XFER_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          seen_q <= 1'b0;
`ifdef CODMA_XFER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if ((state_q == S_RD_WAIT) ? rd_busy_i : wr_busy_i) seen_q <= 1'b1;
`ifdef CODMA_XFER_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (tmo_hit && !bus_error_i) timeout_q <= 1'b1;
`endif
        end
        S_NEXT: begin
          src_q        <= src_q + ADDR_W'(chunk_bytes);
          dst_q        <= dst_q + ADDR_W'(chunk_bytes);
          rem_q        <= rem_q - chunk_len;
          bytes_done_q <= bytes_done_q + chunk_len;
          done_q       <= (rem_q == chunk_len);
        end
        default: ;
      endcase
      // placed after the case so it overrides the clear on a rejected start
      if (state_d == S_ERR) error_q <= 1'b1;
    end
  end

  assign in_rd_phase  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign in_wr_phase  = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign need_read_o  = (state_q == S_RD_REQ);
  assign need_write_o = (state_q == S_WR_REQ);
  assign chunk_addr_o = in_rd_phase ? src_q : (in_wr_phase ? dst_q : '0);
  assign chunk_size_o = (in_rd_phase || in_wr_phase) ? size_code : 8'd0;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign bytes_done_o = bytes_done_q;

endmodule

// File: tb/tb_codma_xfer_ctrl.sv
// tb/tb_codma_xfer_ctrl.sv - scoreboard bench for codma_xfer_ctrl with read/write machine models.
module tb_codma_xfer_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] length_i;
  logic        need_read_o, need_write_o;
  logic        rd_busy_i, wr_busy_i, bus_error_i;
  logic [31:0] chunk_addr_o;
  logic [7:0]  chunk_size_o;
  logic        busy_o, done_o, error_o;
  logic [15:0] bytes_done_o;
`ifdef CODMA_XFER_TIMEOUT_EN
  logic        timeout_o;
`endif

  codma_xfer_ctrl #(.ADDR_W(32), .LEN_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .length_i(length_i),
    .need_read_o(need_read_o), .need_write_o(need_write_o),
    .rd_busy_i(rd_busy_i), .wr_busy_i(wr_busy_i), .bus_error_i(bus_error_i),
    .chunk_addr_o(chunk_addr_o), .chunk_size_o(chunk_size_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
`ifdef CODMA_XFER_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .bytes_done_o(bytes_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  size;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0, rd_num = 0, wr_num = 0;
  int   rd_left = 0, wr_left = 0;
  int   inj_rd = 0;
  bit   rd_stuck = 1'b0;

  // Monitor plus machine models; busy lasts 4 cycles after each request
  always @(negedge clk_i) begin
    if (need_read_o || need_write_o) begin
      checks++;
      if (need_read_o && need_write_o) begin
        errors++;
        $display("FAIL req_overlap: need_read_o=1 need_write_o=1, required never both");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: wr=%0b addr=%h size=%0d, required no request",
                 need_write_o, chunk_addr_o, chunk_size_o);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        if (e.wr !== need_write_o || e.addr !== chunk_addr_o || e.size !== chunk_size_o) begin
          errors++;
          $display("FAIL req_match: got wr=%0b addr=%h size=%0d, required wr=%0b addr=%h size=%0d",
                   need_write_o, chunk_addr_o, chunk_size_o, e.wr, e.addr, e.size);
        end
      end
    end
    if (done_o) done_cnt++;
    if (!reset_n_i) begin
      rd_left = 0;
      wr_left = 0;
    end else begin
      if (rd_left > 0) rd_left--;
      if (wr_left > 0) wr_left--;
      if (need_read_o) begin rd_left = 4; rd_num++; end
      if (need_write_o) begin wr_left = 4; wr_num++; end
    end
    rd_busy_i   = rd_stuck || (rd_left != 0);
    wr_busy_i   = (wr_left != 0);
    bus_error_i = (inj_rd != 0) && (rd_num == inj_rd) && (rd_left != 0);
  end

  task automatic push_chunks(input logic [31:0] s, input logic [31:0] d, input int len);
    int rem = len;
    while (rem > 0) begin
      int  n  = (rem >= 32) ? 32 : ((rem >= 16) ? 16 : 8);
      logic [7:0] c = (n == 32) ? 8'd9 : ((n == 16) ? 8'd8 : 8'd3);
      exp_q.push_back('{1'b0, s, c});
      exp_q.push_back('{1'b1, d, c});
      s = s + n;
      d = d + n;
      rem = rem - n;
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk_i);
    src_addr_i = s;
    dst_addr_i = d;
    length_i   = l;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; length_i = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({need_read_o, need_write_o, busy_o, done_o, error_o} !== 5'b0 ||
        chunk_addr_o !== 32'h0 || chunk_size_o !== 8'h0 || bytes_done_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%0b wr=%0b busy=%0b done=%0b err=%0b addr=%h size=%0d bytes=%0d, required all 0",
               need_read_o, need_write_o, busy_o, done_o, error_o, chunk_addr_o, chunk_size_o, bytes_done_o);
    end
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic run_ok(input string name, input logic [31:0] s, input logic [31:0] d, input int len);
    bit ok;
    done_cnt = 0;
    push_chunks(s, d, len);
    kick(s, d, 16'(len));
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: busy_o stuck high, required idle", name); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: %0d pulses, required 1", name, done_cnt); end
    checks++;
    if (bytes_done_o !== 16'(len) || error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: bytes=%0d err=%0b, required bytes=%0d err=0", name, bytes_done_o, error_o, len);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d requests outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_basic;
    run_ok("basic64", 32'h1000, 32'h2000, 64);
  endtask

  task automatic test_mixed_sizes;
    run_ok("mixed56", 32'h3000, 32'h4000, 56);
  endtask

  task automatic test_zero_len;
    int rd0 = rd_num;
    kick(32'h1111_0000, 32'h2222_0000, 16'd0);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: done=%0b busy=%0b, required done=1 busy=0", done_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || rd_num != rd0) begin
      errors++;
      $display("FAIL zero_len_after: done=%0b reads=%0d, required done=0 reads=0", done_o, rd_num - rd0);
    end
  endtask

  task automatic test_misaligned;
    int rd0 = rd_num;
    done_cnt = 0;
    kick(32'h1000, 32'h2000, 16'd12);
    checks++;
    if (error_o !== 1'b1) begin errors++; $display("FAIL misaligned_err: error_o=%0b, required 1", error_o); end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL misaligned_busy: busy_o=%0b, required 0", busy_o); end
    repeat (2) @(negedge clk_i);
    checks++;
    if (rd_num != rd0 || done_cnt != 0 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_side: reads=%0d done=%0d err=%0b, required 0 0 1", rd_num - rd0, done_cnt, error_o);
    end
  endtask

  task automatic test_bus_error;
    bit ok;
    int wr0 = wr_num;
    done_cnt = 0;
    inj_rd = rd_num + 2;
    exp_q.push_back('{1'b0, 32'h5000, 8'd9});
    exp_q.push_back('{1'b1, 32'h6000, 8'd9});
    exp_q.push_back('{1'b0, 32'h5020, 8'd9});
    kick(32'h5000, 32'h6000, 16'd64);
    wait_idle(400, ok);
    repeat (5) @(negedge clk_i);
    inj_rd = 0;
    checks++;
    if (!ok || error_o !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL buserr_status: idle=%0b err=%0b done=%0d, required 1 1 0", ok, error_o, done_cnt);
    end
    checks++;
    if (wr_num - wr0 != 1 || bytes_done_o !== 16'd32) begin
      errors++;
      $display("FAIL buserr_progress: writes=%0d bytes=%0d, required 1 32", wr_num - wr0, bytes_done_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL buserr_missing: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_addr_wrap;
    run_ok("wrap32", 32'hFFFF_FFF0, 32'h0000_0100, 32);
    run_ok("wrap64", 32'hFFFF_FFF0, 32'hFFFF_FFE0, 64);
  endtask

  task automatic test_busy_start;
    bit ok;
    done_cnt = 0;
    push_chunks(32'h9000, 32'hA000, 16);
    kick(32'h9000, 32'hA000, 16'd16);
    repeat (3) @(negedge clk_i);
    src_addr_i = 32'hDEAD_0000; length_i = 16'd32; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || done_cnt != 1 || bytes_done_o !== 16'd16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_start: idle=%0b done=%0d bytes=%0d left=%0d, required 1 1 16 0",
               ok, done_cnt, bytes_done_o, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    exp_q.push_back('{1'b0, 32'h7000, 8'd9});
    exp_q.push_back('{1'b1, 32'h7800, 8'd9});
    kick(32'h7000, 32'h7800, 16'd64);
    for (int i = 0; i < 50; i++) begin
      if (need_write_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL resetmid_wr: no need_write_o, required one"); end
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({need_read_o, need_write_o, busy_o, done_o, error_o} !== 5'b0 ||
        chunk_addr_o !== 32'h0 || chunk_size_o !== 8'h0 || bytes_done_o !== 16'h0) begin
      errors++;
      $display("FAIL resetmid_outputs: rd=%0b wr=%0b busy=%0b done=%0b err=%0b addr=%h bytes=%0d, required all 0",
               need_read_o, need_write_o, busy_o, done_o, error_o, chunk_addr_o, bytes_done_o);
    end
    exp_q.delete();
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    run_ok("after_reset", 32'h0000_8000, 32'h0000_C000, 24);
  endtask

`ifdef CODMA_XFER_TIMEOUT_EN
  task automatic test_timeout;
    bit seen = 1'b0;
    bit ok;
    rd_stuck = 1'b1;
    exp_q.push_back('{1'b0, 32'hB000, 8'd3});
    kick(32'hB000, 32'hC000, 16'd8);
    for (int i = 0; i < 10; i++) begin
      if (need_read_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    repeat (16) @(negedge clk_i);
    checks++;
    if (!seen || error_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: req=%0b err=%0b, required 1 0", seen, error_o);
    end
    @(negedge clk_i);
    checks++;
    if (error_o !== 1'b1 || timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: err=%0b tmo=%0b, required 1 1", error_o, timeout_o);
    end
    rd_stuck = 1'b0;
    wait_idle(50, ok);
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mixed_sizes();
    test_zero_len();
    test_misaligned();
    test_bus_error();
    test_addr_wrap();
    test_busy_start();
    test_reset_mid();
`ifdef CODMA_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/codma_xfer_ctrl.md
Name: codma_xfer_ctrl

Overview:
- Transfer sequencer for the CODMA.
- Accepts one copy descriptor (source, destination, byte length) and splits it into bus-sized chunks of 32, 16 or 8 bytes.
- For each chunk, drives the read machine first, then the write machine; the shared 8x32-bit data register carries data between them.
- Sits between the CODMA register/command front end and the read_machine/write_machine pair. Reports busy, done and error.

Parameters:
- ADDR_W, 32, width of source/destination addresses.
- LEN_W, 16, width of byte-length field and bytes-done counter.
- TIMEOUT_CYCLES, 1024, watchdog limit per wait phase; used only with CODMA_XFER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous reset, active low
- start_i  in  1  descriptor valid; sampled only in IDLE
- src_addr_i  in  ADDR_W  source byte address
- dst_addr_i  in  ADDR_W  destination byte address
- length_i  in  LEN_W  byte count; must be a multiple of 8
- need_read_o  out  1  one-cycle request to read machine
- need_write_o  out  1  one-cycle request to write machine
- rd_busy_i  in  1  read machine state != RD_IDLE
- wr_busy_i  in  1  write machine state != WR_IDLE
- bus_error_i  in  1  bus error flag
- chunk_addr_o  out  ADDR_W  address for current request (src in read phase, dst in write phase)
- chunk_size_o  out  8  bus size code: 9=32 B, 8=16 B, 3=8 B
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on successful completion
- error_o  out  1  sticky error; cleared on next accepted start
- bytes_done_o  out  LEN_W  bytes fully written so far

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-low on reset_n_i.
- Reset values: all outputs 0, state IDLE. Reset asserted mid-transfer aborts immediately: no done_o, error_o = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, ERR.
- IDLE, start_i=1:
  - Latch src, dst and remaining = length_i; clear error_o and bytes_done_o.
  - length_i == 0: done_o pulses on the next cycle; state stays IDLE.
  - length_i[2:0] != 0: go to ERR.
  - Otherwise go to RD_REQ.
- Chunk size is computed from remaining: >=32 gives code 9 (32 B); else >=16 gives 8 (16 B); else 3 (8 B). It is held stable from RD_REQ through WR_WAIT.
- RD_REQ:
  - need_read_o=1 for exactly one cycle; chunk_addr_o=src.
  - Next state RD_WAIT; clear the "seen" flag.
- RD_WAIT:
  - Set "seen" when rd_busy_i=1.
  - When seen=1 and rd_busy_i=0, go to WR_REQ.
- WR_REQ:
  - need_write_o=1 for one cycle; chunk_addr_o=dst.
  - Next state WR_WAIT; clear "seen".
- WR_WAIT: same seen/falling-busy rule on wr_busy_i, then go to NEXT.
- NEXT (1 cycle):
  - src += chunk bytes, dst += chunk bytes, modulo 2^ADDR_W (wrap, no error).
  - remaining -= chunk bytes; bytes_done_o += chunk bytes.
  - remaining == 0: done_o=1, go to IDLE. Otherwise go to RD_REQ.
- bus_error_i=1 in RD_WAIT or WR_WAIT goes to ERR. If this coincides with the busy falling edge, the error wins.
  - Error in read phase: no write is issued for that chunk.
  - bytes_done_o is not updated for the failed chunk.
- ERR (1 cycle): error_o=1, go to IDLE. done_o is not pulsed.
- Busy/start interaction: start_i while busy_o=1 is ignored. need_read_o and need_write_o are never high together.
- Latency, 32 B chunk with zero-wait machines: RD_REQ to WR_REQ is at least 3 cycles.

Optional Feature:
- Macro: CODMA_XFER_TIMEOUT_EN.
- Enabled:
  - A per-phase counter resets on entering RD_WAIT or WR_WAIT and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES goes to ERR with error_o=1, the same as a bus error.
  - Port timeout_o (1 bit, sticky, cleared on start) is also set.
- Disabled: no counter and no timeout_o port; the wait states wait indefinitely.

Test Plan:
- start, src=0x1000, dst=0x2000, len=64; machine models busy 4 cycles -> reads at 0x1000/0x1020 and writes at 0x2000/0x2020, all size 9; done_o single pulse; bytes_done_o=64.
- len=56 -> chunk sizes 9, 8, 3 in order; addresses +0, +32, +48; done_o after third write.
- len=0 -> done_o pulse one cycle after start; no need_read_o; len=12 -> error_o=1, no requests, busy_o low within 2 cycles.
- bus_error_i=1 during second RD_WAIT of len=64 -> error_o=1, only one need_write_o total, bytes_done_o=32, no done_o.
- src=0xFFFFFFF0, len=32 (one size-9 chunk); verify no error and that the next-chunk increment wraps to 0x00000010. Separately, reset_n_i low during WR_WAIT -> all outputs 0 next cycle; a new start is then accepted normally.
- CODMA_XFER_TIMEOUT_EN, TIMEOUT_CYCLES=16, rd_busy_i stuck high -> error_o and timeout_o set 16 cycles after entering RD_WAIT.
